muldiv_ctrl: RTL and testbench

Sequencing controller for the HI/LO multiply/divide datapath. It sits between the EX stage and the free-running multiplier/divider IP pipelines (signed and unsigned). It accepts one mul/div/mthi/mtlo operation at a time and holds the operands stable for the IP latency. It stalls the pipeline for a fixed number of cycles, then captures the selected IP result into architectural HI/LO registers. It supports flush (exception cancel) at any point.

---
 rtl/muldiv_pkg.sv | 13 +
 rtl/muldiv_ctrl.sv | 78 +++++++
 tb/tb_muldiv_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM states and latency defaults for the HI/LO controller
package muldiv_pkg;
  localparam logic [3:0] OP_NONE  = 4'b0000;
  localparam logic [3:0] OP_MULT  = 4'b0101;
  localparam logic [3:0] OP_MULTU = 4'b0110;
  localparam logic [3:0] OP_DIV   = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b0111;
  localparam logic [3:0] OP_MTHI  = 4'b1000;
  localparam logic [3:0] OP_MTLO  = 4'b1001;
  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 31;
  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT} state_t;
endpackage

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences one mul/div through the external IPs and captures the result into HI/LO
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic [31:0] opnd_a,
  output logic [31:0] opnd_b,
  input  logic [63:0] mul_p,
  input  logic [63:0] mulu_p,
  input  logic [63:0] div_dout,
  input  logic [63:0] divu_dout,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  state_t      state;
  logic [5:0]  cnt;
  logic [3:0]  kind;
  logic        is_mul, is_div, accept, capture;
  logic [31:0] res_hi, res_lo;
  // classify the presented op, derive the stall and pick the result of the op in flight
  always_comb begin
    is_mul  = op == OP_MULT || op == OP_MULTU;
    is_div  = op == OP_DIV || op == OP_DIVU;
    accept  = state == IDLE && op_valid && !flush && (is_mul || is_div);
    busy    = state != IDLE;
    capture = busy && cnt == 6'd1;
    stall   = accept || (busy && !capture && !flush);
    res_hi  = kind == OP_MULT ? mul_p[63:32] : kind == OP_MULTU ? mulu_p[63:32] :
              kind == OP_DIV ? div_dout[31:0] : divu_dout[31:0];
    res_lo  = kind == OP_MULT ? mul_p[31:0] : kind == OP_MULTU ? mulu_p[31:0] :
              kind == OP_DIV ? div_dout[63:32] : divu_dout[63:32];
  end
  // control FSM: latch operands on accept, count down the IP latency, write HI/LO on the last cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      kind   <= OP_NONE;
      opnd_a <= '0;
      opnd_b <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        opnd_a <= src_a;
        opnd_b <= src_b;
        kind   <= op;
        cnt    <= is_mul ? 6'(MUL_LAT) : 6'(DIV_LAT);
        state  <= is_mul ? MUL_WAIT : DIV_WAIT;
      end else if (op_valid && op == OP_MTHI) begin
        hi <= src_a;
      end else if (op_valid && op == OP_MTLO) begin
        lo <= src_a;
      end
    end else begin
      cnt <= cnt - 6'd1;
      if (capture) begin
        state <= IDLE;
        hi    <= res_hi;
        lo    <= res_lo;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: table-driven scoreboard bench for the HI/LO mul/div controller
module tb_muldiv_ctrl;
  import muldiv_pkg::*;
  localparam int ML = 5;
  localparam int DL = 31;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;
  logic        clk = 0, rst = 1, op_valid = 0, flush = 0;
  logic [3:0]  op = OP_NONE;
  logic [31:0] src_a = 0, src_b = 0, opnd_a, opnd_b, hi, lo;
  logic [63:0] mul_p, mulu_p, div_dout, divu_dout;
  logic        stall, busy;
  int          checks = 0, errors = 0;
  logic [63:0] sb[$];
  logic        pend = 0;
  vec_t        tbl[9];
  always #5 clk = ~clk;
  // reference IP behaviour: mul gives {hi,lo}, div gives {quotient,remainder}
  function automatic logic [63:0] ip(input logic [3:0] k, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb_ = longint'($signed(b));
    logic [63:0] ua = {32'b0, a};
    logic [63:0] ub = {32'b0, b};
    if (k == OP_MULT) return 64'(sa * sb_);
    if (k == OP_MULTU) return ua * ub;
    if (b == 0) return 64'b0;
    if (k == OP_DIV) return {32'(sa / sb_), 32'(sa % sb_)};
    return {a / b, a % b};
  endfunction
  assign mul_p     = ip(OP_MULT, opnd_a, opnd_b);
  assign mulu_p    = ip(OP_MULTU, opnd_a, opnd_b);
  assign div_dout  = ip(OP_DIV, opnd_a, opnd_b);
  assign divu_dout = ip(OP_DIVU, opnd_a, opnd_b);
  muldiv_ctrl #(.MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .opnd_a(opnd_a), .opnd_b(opnd_b), .mul_p(mul_p), .mulu_p(mulu_p),
    .div_dout(div_dout), .divu_dout(divu_dout), .stall(stall), .busy(busy), .hi(hi), .lo(lo)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // scoreboard monitor: a capture cycle is flagged, HI/LO compared one cycle later
  always begin
    @(negedge clk);
    #3;
    if (pend) begin
      pend = 0;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL hilo_unexpected: got %h expected none", {hi, lo});
      end else chk("hilo", {hi, lo}, sb.pop_front());
    end
    if (!rst && busy && !stall && !flush) pend = 1;
  end
  task automatic run_op(input vec_t v);
    int   n = 0;
    logic stable = 1;
    @(negedge clk);
    op_valid = 1; op = v.op; src_a = v.a; src_b = v.b;
    sb.push_back({v.hi, v.lo});
    #1;
    while (stall && n < 200) begin
      @(negedge clk);
      n++;
      #1;
      if (busy) stable &= opnd_a == v.a && opnd_b == v.b;
    end
    chk("stall_len", 64'(n), (v.op == OP_MULT || v.op == OP_MULTU) ? 64'(ML) : 64'(DL));
    chk("opnd_stable", 64'(stable), 64'd1);
    chk("busy_capture", 64'(busy), 64'd1);
    op_valid = 0;
  endtask
  initial begin
    logic [63:0] prev, r;
    tbl[0] = '{OP_MULT,  32'hFFFFFFFE, 32'd3,       32'hFFFFFFFF, 32'hFFFFFFFA};
    tbl[1] = '{OP_DIVU,  32'd100,      32'd7,       32'd2,        32'd14};
    tbl[2] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,       32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tbl[4] = '{OP_DIVU,  32'd10,       32'd3,       32'd1,        32'd3};
    for (int i = 5; i < 9; i++) begin
      logic [3:0] k;
      k = (i == 5) ? OP_MULT : (i == 6) ? OP_MULTU : (i == 7) ? OP_DIV : OP_DIVU;
      tbl[i].op = k;
      tbl[i].a  = $urandom;
      tbl[i].b  = (k == OP_DIV || k == OP_DIVU) ? 32'($urandom_range(1, 1000)) : $urandom;
      r = ip(k, tbl[i].a, tbl[i].b);
      {tbl[i].hi, tbl[i].lo} = (k == OP_MULT || k == OP_MULTU) ? r : {r[31:0], r[63:32]};
    end
    #1;
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_ctrl", {62'd0, stall, busy}, 64'd0);
    chk("rst_opnd", {opnd_a, opnd_b}, 64'd0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 9; i++) run_op(tbl[i]);
    @(negedge clk);
    #1;
    chk("busy_after", 64'(busy), 64'd0);
    op_valid = 1; op = OP_MTHI; src_a = 32'h12345678;
    #1;
    chk("mthi_stall", 64'(stall), 64'd0);
    @(negedge clk);
    op = OP_MTLO; src_a = 32'h9ABCDEF0;
    #1;
    chk("mthi_hi", {32'd0, hi}, {32'd0, 32'h12345678});
    chk("mtlo_stall", {62'd0, stall, busy}, 64'd0);
    @(negedge clk);
    op_valid = 0;
    #1;
    chk("mtlo_lo", {32'd0, lo}, {32'd0, 32'h9ABCDEF0});
    prev = {hi, lo};
    op_valid = 1; op = OP_MULT; src_a = 32'd7; src_b = 32'd9;
    @(negedge clk);
    op_valid = 0;
    repeat (2) @(negedge clk);
    flush = 1;
    #1;
    chk("flush_w3_stall", {62'd0, stall, busy}, 64'd1);
    @(negedge clk);
    flush = 0;
    #1;
    chk("flush_w3_busy", 64'(busy), 64'd0);
    chk("flush_w3_hilo", {hi, lo}, prev);
    op_valid = 1; op = OP_MULTU; src_a = 32'd11; src_b = 32'd13;
    @(negedge clk);
    op_valid = 0;
    repeat (ML - 1) @(negedge clk);
    flush = 1;
    #1;
    chk("flush_cap_state", {62'd0, stall, busy}, 64'd1);
    @(negedge clk);
    flush = 0;
    #1;
    chk("flush_cap_hilo", {hi, lo}, prev);
    chk("flush_cap_busy", 64'(busy), 64'd0);
    op_valid = 1; op = OP_MTHI; src_a = 32'hDEADBEEF; flush = 1;
    #1;
    chk("flush_idle_stall", 64'(stall), 64'd0);
    @(negedge clk);
    op = OP_DIV;
    #1;
    chk("flush_idle_mthi", {hi, lo}, prev);
    chk("flush_idle_acc", {62'd0, stall, busy}, 64'd0);
    @(negedge clk);
    flush = 0; op_valid = 1; op = OP_DIVU; src_a = 32'd50; src_b = 32'd5;
    @(negedge clk);
    op_valid = 0;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1;
    #1;
    chk("async_rst_hilo", {hi, lo}, 64'd0);
    chk("async_rst_ctrl", {62'd0, stall, busy}, 64'd0);
    chk("async_rst_opnd", {opnd_a, opnd_b}, 64'd0);
    @(negedge clk);
    rst = 0;
    run_op(tbl[2]);
    repeat (2) @(negedge clk);
    #4;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
